// File: rtl/melody_pkg.sv
// Shared types, tempo codes and melody ROM for the melody sequencer.
// Durations are in ticks; notes use the tone generator's 3-bit code map.
package melody_pkg;

  localparam int SEQ_LEN = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef logic [2:0] note_t;

  localparam logic [1:0] TEMPO_X1      = 2'b00;
  localparam logic [1:0] TEMPO_X2      = 2'b01;
  localparam logic [1:0] TEMPO_HALF    = 2'b10;
  localparam logic [1:0] TEMPO_QUARTER = 2'b11;

  localparam note_t MEL_NOTE [SEQ_LEN] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
  };

  localparam logic [11:0] MEL_DUR [SEQ_LEN] = '{
    12'd250, 12'd250, 12'd250, 12'd250,
    12'd250, 12'd250, 12'd250, 12'd500
  };

  // Tempo-scaled duration; a zero result would never expire, so clamp to 1.
  function automatic logic [11:0] scale_dur(
    input logic [11:0] d,
    input logic [1:0]  t
  );
    logic [11:0] r;
    case (t)
      TEMPO_X2:      r = d << 1;
      TEMPO_HALF:    r = d >> 1;
      TEMPO_QUARTER: r = d >> 2;
      default:       r = d;
    endcase
    if (r == 12'd0) r = 12'd1;
    return r;
  endfunction

endpackage

// File: rtl/melody_sequencer_tick_gen.sv
// Divides the system clock down to a one-cycle timing tick.
// Held at phase zero while clr is high so each note starts on a fresh period.
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic CLOCK_50M,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int N = CLK_HZ / TICK_HZ;
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  // Free-running divider, restarted by clr.
  always_ff @(posedge CLOCK_50M or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || cnt == W'(N - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == W'(N - 1));

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM, timing each note and gap in ticks.
// Drives the tone generator's note code and enable; all outputs registered.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int GAP_TICKS = 20
) (
  input  logic       CLOCK_50M,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] tempo,
  output logic [2:0] note_sel,
  output logic       tone_en,
  output logic       busy,
  output logic [2:0] step_idx,
  output logic       done
);

  state_t      state, state_n;
  logic [2:0]  step_n;
  note_t       note_n;
  logic [11:0] dur_cnt, dur_n;
  logic [11:0] gap_cnt, gap_n;
  logic        start_q;
  logic        start_pulse;
  logic        tick;
  logic        last_step;
  logic        gap_end;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .CLOCK_50M(CLOCK_50M),
    .reset    (reset),
    .clr      (state == IDLE || state == LOAD),
    .tick     (tick)
  );

  assign start_pulse = start & ~start_q;
  assign last_step   = (step_idx == 3'(SEQ_LEN - 1));
  assign gap_end     = (gap_cnt == 12'd0) || (tick && gap_cnt == 12'd1);

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge CLOCK_50M or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      step_idx <= '0;
      note_sel <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      start_q  <= 1'b0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      step_idx <= step_n;
      note_sel <= note_n;
      dur_cnt  <= dur_n;
      gap_cnt  <= gap_n;
      start_q  <= start;
      tone_en  <= (state_n == PLAY);
      busy     <= (state_n == LOAD) || (state_n == PLAY) || (state_n == GAP);
      done     <= (state_n == DONE);
    end
  end

  // Next-state logic; stop wins in every active state.
  always_comb begin
    state_n = state;
    step_n  = step_idx;
    note_n  = note_sel;
    dur_n   = dur_cnt;
    gap_n   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (start_pulse && !stop) begin
          step_n  = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_n = IDLE;
        end else begin
          note_n  = MEL_NOTE[step_idx];
          dur_n   = scale_dur(MEL_DUR[step_idx], tempo);
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tick) begin
          if (dur_cnt == 12'd1) begin
            gap_n   = 12'(GAP_TICKS);
            state_n = GAP;
          end else begin
            dur_n = dur_cnt - 12'd1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_n = IDLE;
        end else if (gap_end) begin
          if (!last_step) begin
            step_n  = step_idx + 3'd1;
            state_n = LOAD;
          end else if (loop_en) begin
            step_n  = '0;
            state_n = LOAD;
          end else begin
            state_n = DONE;
          end
        end else if (tick) begin
          gap_n = gap_cnt - 12'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a cycle-count reference model.
// Scaled clocking: 10 cycles per tick, 2-tick gap.
module tb_melody_sequencer;

  localparam int N   = 10;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [1:0] tempo;
  logic [2:0] note_sel;
  logic       tone_en;
  logic       busy;
  logic [2:0] step_idx;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  melody_sequencer #(
    .CLK_HZ   (100),
    .TICK_HZ  (10),
    .GAP_TICKS(GAP)
  ) dut (
    .CLOCK_50M(clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .tempo    (tempo),
    .note_sel (note_sel),
    .tone_en  (tone_en),
    .busy     (busy),
    .step_idx (step_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  int NOTES [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int DURS  [8] = '{250, 250, 250, 250, 250, 250, 250, 500};

  // Model: phase 0 idle, 1 load, 2 sounding, 3 silent gap, 4 done.
  int ph, left, m_step, m_note;
  bit m_sq, sp;

  function automatic int play_cycles(input int d, input logic [1:0] t);
    int r;
    case (t)
      2'b01:   r = d * 2;
      2'b10:   r = d / 2;
      2'b11:   r = d / 4;
      default: r = d;
    endcase
    if (r < 1) r = 1;
    return r * N;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0; left = 0; m_step = 0; m_note = 0; m_sq = 0;
    end else begin
      sp = start && !m_sq;
      m_sq = start;
      case (ph)
        0: if (sp && !stop) begin m_step = 0; ph = 1; end
        1: if (stop) ph = 0;
           else begin
             m_note = NOTES[m_step];
             left = play_cycles(DURS[m_step], tempo);
             ph = 2;
           end
        2: if (stop) ph = 0;
           else begin
             left--;
             if (left == 0) begin
               ph = 3;
               left = (GAP > 0) ? GAP * N : 1;
             end
           end
        3: if (stop) ph = 0;
           else begin
             left--;
             if (left == 0) begin
               if (m_step < 7) begin m_step++; ph = 1; end
               else if (loop_en) begin m_step = 0; ph = 1; end
               else ph = 4;
             end
           end
        default: ph = 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [8:0] act, exp;
    act = {note_sel, tone_en, busy, step_idx, done};
    exp = {3'(m_note), ph == 2, ph >= 1 && ph <= 3, 3'(m_step), ph == 4};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle t=%0t got {note,tone,busy,step,done}=%b want %b",
               $time, act, exp);
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (tone_en === v && n < 20000) begin n++; @(negedge clk); end
  endtask

  task automatic wait_tone(input logic v, input int lim, output bit ok);
    int k = 0;
    while (tone_en !== v && k < lim) begin k++; @(negedge clk); end
    ok = (tone_en === v);
  endtask

  task automatic wait_step_on(input int s, input int lim, output bit ok);
    int k = 0;
    while (!(step_idx == 3'(s) && tone_en === 1'b1) && k < lim) begin
      k++; @(negedge clk);
    end
    ok = (step_idx == 3'(s) && tone_en === 1'b1);
  endtask

  task automatic wait_done(input int lim, output bit ok);
    int k = 0;
    while (done !== 1'b1 && k < lim) begin k++; @(negedge clk); end
    ok = (done === 1'b1);
  endtask

  initial begin
    int n, g, d0;
    bit ok;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; tempo = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_outs", {note_sel, tone_en, busy, step_idx, done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("scale_clamp", melody_pkg::scale_dur(12'd3, 2'b11), 1);
    check("scale_q250", melody_pkg::scale_dur(12'd250, 2'b11), 62);

    // Full melody at x1, no loop; start re-toggled while busy.
    start = 1'b1;
    wait_tone(1'b1, 20, ok);
    check("s0_start", ok, 1);
    check("s0_note", note_sel, 0);
    run_len(1'b1, n);
    check("s0_high", n, 2500);
    g = 0;
    while (tone_en === 1'b0 && step_idx == 3'd0 && g < 100) begin
      g++; @(negedge clk);
    end
    check("s0_gap", g, 20);
    wait_tone(1'b1, 20, ok);
    check("s1_note", note_sel, 1);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_step_on(7, 30000, ok);
    check("s7_reach", ok, 1);
    run_len(1'b1, n);
    check("s7_high", n, 5000);
    wait_done(100, ok);
    check("done_seen", ok, 1);
    check("done_busy", busy, 0);
    @(negedge clk);
    check("done_width", done, 0);
    check("final_step", step_idx, 7);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during step 3 sounding.
    tempo = 2'b11;
    start = 1'b1;
    wait_step_on(3, 5000, ok);
    check("s3_reach", ok, 1);
    #2 reset = 1'b1;
    #1 check("rst_async", {tone_en, busy}, 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_idle", {note_sel, tone_en, busy, step_idx, done}, 0);

    // Quarter tempo durations.
    start = 1'b1;
    wait_tone(1'b1, 20, ok);
    run_len(1'b1, n);
    check("q_s0_high", n, 620);
    wait_step_on(7, 8000, ok);
    run_len(1'b1, n);
    check("q_s7_high", n, 1250);
    wait_done(100, ok);
    check("q_done", ok, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Looping, then stop during step 4.
    loop_en = 1'b1;
    d0 = done_cnt;
    start = 1'b1;
    wait_step_on(7, 8000, ok);
    check("l_s7", ok, 1);
    run_len(1'b1, n);
    wait_tone(1'b1, 100, ok);
    check("l_wrap", ok, 1);
    check("l_step0", step_idx, 0);
    check("l_note0", note_sel, 0);
    wait_step_on(4, 5000, ok);
    check("l_s4", ok, 1);
    stop = 1'b1;
    @(negedge clk);
    check("stop_outs", {note_sel, tone_en, busy, step_idx, done},
          {3'd4, 1'b0, 1'b0, 3'd4, 1'b0});
    check("l_no_done", done_cnt, d0);
    repeat (4) @(negedge clk);
    stop = 1'b0;
    repeat (50) @(negedge clk);
    check("no_restart", busy, 0);
    start = 1'b0;
    loop_en = 1'b0;
    @(negedge clk);

    // Start edge coinciding with stop is dropped.
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (30) @(negedge clk);
    check("stop_beats_start", busy, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a fixed 8-step melody by driving the note select and enable inputs of the tone generator. The tone generator toggles its audio clock from CLOCK_50M, with its 3-bit note code equal to SW[3:1] and enable equal to SW[0].
- Times each note in millisecond ticks, inserts a silent gap between notes, and supports tempo scaling, looping and abort.
- Sits between the board switches/keys and the tone generator.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1000, timing tick rate; durations are counted in ticks.
- SEQ_LEN, 8, melody length in steps.
- GAP_TICKS, 20, silent ticks inserted after every note.

Ports:
- CLOCK_50M  in   1   system clock
- reset      in   1   asynchronous, active-high reset
- start      in   1   level input; a 0->1 transition starts playback
- stop       in   1   level input; aborts playback while high
- loop_en    in   1   1 = restart at step 0 after the last step
- tempo      in   2   00 x1, 01 x2 (slower), 10 x1/2, 11 x1/4
- note_sel   out  3   note code to the tone generator
- tone_en    out  1   tone generator enable
- busy       out  1   high in every state except IDLE and DONE
- step_idx   out  3   current step index
- done       out  1   one-cycle pulse when a non-looping melody completes

Behaviour:
- Reset (asynchronous): state IDLE; note_sel=0, tone_en=0, busy=0, step_idx=0, done=0. Tick counter, duration counter and start-edge register are cleared. Reset asserted mid-note silences tone_en immediately.
- All outputs are registered.
- start edge detect: start_q registers start; start_pulse = start & ~start_q. Edges seen while busy are ignored.
- Tick: tick_gen asserts a 1-cycle tick every CLK_HZ/TICK_HZ cycles (counter 0..N-1). The counter is held at 0 in IDLE and LOAD. The first tick after LOAD occurs exactly N cycles after the PLAY entry cycle.
- Melody ROM (in package): notes 0,1,2,3,4,5,6,7; durations in ticks 250,250,250,250,250,250,250,500.
- Duration scaling happens in LOAD: x1 = d; x2 = d<<1; x1/2 = d>>1; x1/4 = d>>2. The duration counter is 12 bits. A result of 0 is clamped to 1.
- IDLE: tone_en=0, busy=0. On start_pulse with stop=0, set step_idx=0 and go to LOAD.
- LOAD (1 cycle): note_sel<=rom_note[step_idx]; dur_cnt<=scaled duration. Next state PLAY.
- PLAY: tone_en=1 from the first PLAY cycle. Each tick decrements dur_cnt. A tick with dur_cnt==1 moves to GAP and loads gap_cnt=GAP_TICKS.
- GAP: tone_en=0; note_sel is held. Each tick decrements gap_cnt. A tick with gap_cnt==1 ends the gap; GAP_TICKS=0 means GAP lasts exactly 1 cycle. At the end of the gap:
  - step_idx < SEQ_LEN-1: increment step_idx, go to LOAD.
  - Last step with loop_en=1: step_idx=0, go to LOAD.
  - Last step with loop_en=0: go to DONE.
- loop_en is sampled only at the end of the last step's gap.
- DONE (1 cycle): done=1, busy=0. Next state IDLE; step_idx keeps its final value until the next start.
- stop: in LOAD/PLAY/GAP, stop=1 forces IDLE on the next edge. tone_en=0 from that edge, no done pulse, note_sel and step_idx unchanged. stop beats a simultaneous start_pulse in IDLE. A start held high during stop does not restart after stop releases; a new 0->1 edge is required.
- tempo changes mid-note take effect at the next LOAD.

Decomposition:
- melody_pkg: state enum (IDLE, LOAD, PLAY, GAP, DONE); note_t (3-bit codes matching the tone generator map); tempo encoding constants; ROM arrays MEL_NOTE[SEQ_LEN] and MEL_DUR[SEQ_LEN].
- One sub-module, tick_gen: parameters CLK_HZ and TICK_HZ; inputs CLOCK_50M, reset and clr; output tick.

Test Plan (CLK_HZ=100, TICK_HZ=10, i.e. 10 cycles per tick; GAP_TICKS=2):
- Reset mid-PLAY, step 3 -> tone_en and busy drop to 0 asynchronously; after release, state is IDLE and outputs hold reset values.
- start edge, tempo=00, loop_en=0 ->
  - step 0: note_sel=0, tone_en high for exactly 2500 cycles, then low for 20 cycles; step 1 follows with note_sel=1.
  - step 7: high for 5000 cycles.
  - after the last gap: 1-cycle done, then busy=0.
- tempo=11 -> note 0 plays 62 ticks (620 cycles) and note 7 plays 125 ticks. Separately, a ROM entry of 3 at x1/4 clamps to 1 tick.
- loop_en=1 -> after the step 7 gap, step_idx=0 with note_sel=0; no done pulse; playback continues until stop.
- stop=1 during step 4 PLAY -> next cycle IDLE, tone_en=0, step_idx stays 4, done stays 0. Releasing stop with start still high produces no restart.
- start toggled 0->1 while busy, and start with stop asserted in the same IDLE cycle -> both ignored; the sequence timing is unchanged.
